// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - round-robin next-owner search for the bus arbiter
//
// Ports:
//   owner       in   current bus owner index
//   request_    in   active-low requests, bit i = master i
//   found       out  some master other than the owner is requesting
//   next_owner  out  first requester after owner (owner+1, +2, +3, wrapping);
//                    equals owner when nothing is found
//
// Shared encodings normally come from bus.h and stddef.h; the guarded fallbacks
// below keep this file self-contained when those headers are not on the path.

`ifndef YUTORINA_BUS_MASTER_COUNT
`define YUTORINA_BUS_MASTER_COUNT 4
`endif
`ifndef YutorinaBusOwnerBus
`define YutorinaBusOwnerBus [1:0]
`endif

module bus_arbiter_rr_pick (
  input  logic `YutorinaBusOwnerBus owner,
  input  logic [`YUTORINA_BUS_MASTER_COUNT-1:0] request_,
  output logic found,
  output logic `YutorinaBusOwnerBus next_owner
);

  logic `YutorinaBusOwnerBus idx;

  // Scan from the farthest candidate down to owner+1 so the nearest
  // requester overwrites earlier hits; the owner itself is never a candidate.
  always_comb begin
    found      = 1'b0;
    next_owner = owner;
    idx        = owner;
    for (int k = `YUTORINA_BUS_MASTER_COUNT - 1; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (!request_[idx]) begin
        found      = 1'b1;
        next_owner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with bus parking
//
// Optional feature macro: YUTORINA_BUS_ARBITER_TIMEOUT_EN (hold-time revocation).
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   synchronous reset, active-high
//   master0..3_request_ in   active-low bus requests
//   master0..3_grant_   out  active-low grants, exactly one low at all times
//   owner               out  index of the granted master
//   timeout_            out  active-low pulse in the cycle a hold is revoked;
//                            constant high without the timeout feature
//
// Parameters:
//   TIMEOUT_CYCLES      max consecutive requested-hold cycles before revocation
//   TIMEOUT_WIDTH       hold counter width, must hold TIMEOUT_CYCLES

`ifndef YUTORINA_BUS_MASTER_COUNT
`define YUTORINA_BUS_MASTER_COUNT 4
`endif
`ifndef YutorinaBusOwnerBus
`define YutorinaBusOwnerBus [1:0]
`endif
`ifndef YUTORINA_BUS_OWNER_0
`define YUTORINA_BUS_OWNER_0 2'd0
`define YUTORINA_BUS_OWNER_1 2'd1
`define YUTORINA_BUS_OWNER_2 2'd2
`define YUTORINA_BUS_OWNER_3 2'd3
`endif
`ifndef YUTORINA_BUS_ARB_PARK
`define YUTORINA_BUS_ARB_PARK 1'b0
`define YUTORINA_BUS_ARB_BUSY 1'b1
`endif
`ifndef YUTORINA_ENABLE_
`define YUTORINA_ENABLE_  1'b0
`define YUTORINA_DISABLE_ 1'b1
`endif

module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic master0_request_,
  input  logic master1_request_,
  input  logic master2_request_,
  input  logic master3_request_,
  output logic master0_grant_,
  output logic master1_grant_,
  output logic master2_grant_,
  output logic master3_grant_,
  output logic `YutorinaBusOwnerBus owner,
  output logic timeout_
);

  typedef enum logic {
    PARK = `YUTORINA_BUS_ARB_PARK,
    BUSY = `YUTORINA_BUS_ARB_BUSY
  } arb_state_t;

  arb_state_t state, state_next;
  logic `YutorinaBusOwnerBus owner_next;
  logic `YutorinaBusOwnerBus pick_owner;
  logic [`YUTORINA_BUS_MASTER_COUNT-1:0] request_;
  logic pick_found;
  logic owner_requesting;
  logic timeout_hit;

  assign request_ = {master3_request_, master2_request_,
                     master1_request_, master0_request_};
  assign owner_requesting = !request_[owner];

  bus_arbiter_rr_pick u_rr_pick (
    .owner      (owner),
    .request_   (request_),
    .found      (pick_found),
    .next_owner (pick_owner)
  );

`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] hold_cnt, hold_cnt_next;

  // Revocation only happens when someone else is waiting; otherwise the
  // counter just saturates and the owner keeps the bus.
  assign timeout_hit = (state == BUSY) && owner_requesting && pick_found &&
                       (hold_cnt >= TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    hold_cnt_next = '0;
    if (state == BUSY && owner_requesting && !timeout_hit) begin
      hold_cnt_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_next;
    end
  end

  assign timeout_ = timeout_hit ? `YUTORINA_ENABLE_ : `YUTORINA_DISABLE_;
`else
  // Parameters stay on the interface so both builds share one instantiation;
  // this term is false for every legal setting.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && (TIMEOUT_WIDTH == 0);
  assign timeout_    = `YUTORINA_DISABLE_;
`endif

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      PARK: begin
        if (owner_requesting) begin
          state_next = BUSY;
        end else if (pick_found) begin
          state_next = BUSY;
          owner_next = pick_owner;
        end
      end
      BUSY: begin
        if (timeout_hit) begin
          owner_next = pick_owner;
        end else if (!owner_requesting) begin
          if (pick_found) begin
            owner_next = pick_owner;
          end else begin
            state_next = PARK;
          end
        end
      end
      default: state_next = PARK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PARK;
      owner <= `YUTORINA_BUS_OWNER_0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Grants depend on the registered owner only, so exactly one is low.
  assign master0_grant_ = (owner == `YUTORINA_BUS_OWNER_0) ? `YUTORINA_ENABLE_ : `YUTORINA_DISABLE_;
  assign master1_grant_ = (owner == `YUTORINA_BUS_OWNER_1) ? `YUTORINA_ENABLE_ : `YUTORINA_DISABLE_;
  assign master2_grant_ = (owner == `YUTORINA_BUS_OWNER_2) ? `YUTORINA_ENABLE_ : `YUTORINA_DISABLE_;
  assign master3_grant_ = (owner == `YUTORINA_BUS_OWNER_3) ? `YUTORINA_ENABLE_ : `YUTORINA_DISABLE_;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized self-checking bench for bus_arbiter
module tb_bus_arbiter;

  localparam int T   = 8;
  localparam int W   = 4;
  localparam int SAT = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic m0_req_, m1_req_, m2_req_, m3_req_;
  logic g0_, g1_, g2_, g3_;
  logic [1:0] owner;
  logic timeout_;

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner;
  bit m_busy;
  int m_cnt;
  logic last_to;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .master0_request_ (m0_req_),
    .master1_request_ (m1_req_),
    .master2_request_ (m2_req_),
    .master3_request_ (m3_req_),
    .master0_grant_   (g0_),
    .master1_grant_   (g1_),
    .master2_grant_   (g2_),
    .master3_grant_   (g3_),
    .owner            (owner),
    .timeout_         (timeout_)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input int own, input logic [3:0] rq_n);
    for (int k = 1; k < 4; k++) begin
      if (!rq_n[(own + k) % 4]) return (own + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit model_timeout(input logic [3:0] rq_n);
`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
    return m_busy && !rq_n[m_owner] && (m_cnt >= T - 1) && (rr_next(m_owner, rq_n) >= 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic [3:0] rq_n, input logic rst);
    int nxt;
    bit own_req;
    bit to;
    if (rst) begin
      m_owner = 0; m_busy = 0; m_cnt = 0;
      return;
    end
    nxt = rr_next(m_owner, rq_n);
    own_req = !rq_n[m_owner];
    to = model_timeout(rq_n);
    if (!m_busy) begin
      if (own_req) begin m_busy = 1; m_cnt = 0; end
      else if (nxt >= 0) begin m_owner = nxt; m_busy = 1; m_cnt = 0; end
    end else if (to) begin
      m_owner = nxt; m_cnt = 0;
    end else if (own_req) begin
      if (m_cnt < SAT) m_cnt++;
    end else if (nxt >= 0) begin
      m_owner = nxt; m_cnt = 0;
    end else begin
      m_busy = 0; m_cnt = 0;
    end
  endtask

  task automatic cycle(input logic [3:0] rq_n, input logic rst);
    logic [3:0] exp_g;
    @(negedge clk);
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = rq_n;
    #1;
    exp_g = 4'b1111;
    exp_g[m_owner] = 1'b0;
    last_to = timeout_;
    check("grant_", {28'd0, g3_, g2_, g1_, g0_}, {28'd0, exp_g});
    check("owner", {30'd0, owner}, m_owner);
    check("timeout_", {31'd0, timeout_}, {31'd0, !model_timeout(rq_n)});
    @(posedge clk);
    model_step(rq_n, rst);
  endtask

  task automatic peek(input string tag, input int exp_owner);
    logic [3:0] exp_g;
    #1;
    exp_g = 4'b1111;
    exp_g[exp_owner] = 1'b0;
    check({tag, "_owner"}, {30'd0, owner}, exp_owner);
    check({tag, "_grant_"}, {28'd0, g3_, g2_, g1_, g0_}, {28'd0, exp_g});
  endtask

  initial begin
    int seq_exp [4] = '{1, 2, 3, 0};
    int cur;
    logic [3:0] rq;
    int first_to;
    int pulses;

    reset = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'hF;
    repeat (2) @(posedge clk);
    model_step(4'hF, 1'b1);

    // idle after reset: parked on master 0
    cycle(4'hF, 1'b1);
    peek("reset", 0);
    repeat (10) cycle(4'hF, 1'b0);
    peek("idle10", 0);

    // lone request from master 2, then release and park
    cycle(4'b1011, 1'b0);
    peek("m2_grant", 2);
    repeat (3) cycle(4'hF, 1'b0);
    peek("m2_park", 2);

    // owner 3 releases while 0 and 1 request: wrap to 0
    cycle(4'b0111, 1'b0);
    peek("m3_grant", 3);
    cycle(4'b0111, 1'b0);
    cycle(4'b1100, 1'b0);
    peek("wrap", 0);

    // reset while master 1 holds
    cycle(4'b1101, 1'b0);
    peek("m1_grant", 1);
    cycle(4'b1101, 1'b0);
    cycle(4'b1101, 1'b1);
    peek("rst_mid", 0);

    // all requesting, each owner releases for one cycle after three held
    cycle(4'hF, 1'b1);
    cur = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (3) cycle(4'b0000, 1'b0);
      rq = 4'b0000;
      rq[cur] = 1'b1;
      cycle(rq, 1'b0);
      peek($sformatf("rr%0d", r), seq_exp[r]);
      cur = seq_exp[r];
    end

`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
    // master 0 holds while master 1 waits: revoked in the 8th busy cycle
    cycle(4'hF, 1'b1);
    first_to = -1;
    for (int k = 0; k < 20 && first_to < 0; k++) begin
      cycle(4'b1100, 1'b0);
      if (last_to === 1'b0) begin
        first_to = k;
        peek("to_rotate", 1);
      end
    end
    check("to_cycle", first_to, 8);

    // master 0 holds alone: never revoked
    cycle(4'hF, 1'b1);
    pulses = 0;
    repeat (50) begin
      cycle(4'b1110, 1'b0);
      if (last_to !== 1'b1) pulses++;
    end
    check("to_alone", pulses, 0);
    peek("to_alone", 0);
`else
    first_to = 0;
    pulses = 0;
`endif

    // random traffic with occasional resets, sticky requests to build up holds
    rq = 4'hF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      cycle(rq, ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
